// File: rtl/jk_seq_pkg.sv
// jk_seq_pkg: shared state encoding and JK excitation codes for jk_seq_driver_311
// Excitation codes are packed as {J, K}.
package jk_seq_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, ERR} state_e;
    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] SET  = 2'b10;
    localparam logic [1:0] RST  = 2'b01;
    localparam logic [1:0] TGL  = 2'b11;
endpackage

// File: rtl/jk_seq_driver_311_excite.sv
// jk_excite_311: per-bit JK excitation from current Q to target T
// Ports: q (current bank bit), t (target bit), j/k (excitation).
// Macro JK_SEQ_DRIVER_TOGGLE_EN: drive changing bits with J=K=1 instead of set/reset.
module jk_excite_311
    import jk_seq_pkg::*;
(
    input  logic q,
    input  logic t,
    output logic j,
    output logic k
);
    logic [1:0] code;
`ifdef JK_SEQ_DRIVER_TOGGLE_EN
    assign code = (q != t) ? TGL : HOLD;
`else
    assign code = (q == t) ? HOLD : (t ? SET : RST);
`endif
    assign {j, k} = code;
endmodule

// File: rtl/jk_seq_driver_311.sv
// jk_seq_driver_311: drives an external JK flip-flop bank to a target value with checked retries
// Ports: clk_311 clock; reset sync active-high; start/target request; q_in bank feedback;
//        j_out/k_out registered excitation; busy (DRIVE/CHECK); done one-cycle pulse; err sticky.
// Macro JK_SEQ_DRIVER_TOGGLE_EN selects toggle excitation inside jk_excite_311.
module jk_seq_driver_311
    import jk_seq_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic             clk_311,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
    logic             done_q, done_d, err_q, err_d;
    logic [WIDTH-1:0] ex_t, ex_j, ex_k;
    logic             drive;

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        jk_excite_311 u_exc (.q(q_in[b]), .t(ex_t[b]), .j(ex_j[b]), .k(ex_k[b]));
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        retry_d = retry_q;
        done_d  = 1'b0;
        err_d   = err_q;
        drive   = 1'b0;
        // On acceptance tgt_q is not yet loaded, so excite against the incoming target
        ex_t    = tgt_q;
        case (state_q)
            IDLE, ERR: if (start) begin
                tgt_d   = target;
                retry_d = '0;
                err_d   = 1'b0;
                drive   = 1'b1;
                ex_t    = target;
                state_d = DRIVE;
            end
            DRIVE: state_d = CHECK;
            CHECK: if (q_in == tgt_q) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end else if (retry_q < RW'(MAX_RETRY)) begin
                retry_d = retry_q + 1'b1;
                drive   = 1'b1;
                state_d = DRIVE;
            end else begin
                err_d   = 1'b1;
                state_d = ERR;
            end
            default: state_d = IDLE;
        endcase
        j_d = drive ? ex_j : '0;
        k_d = drive ? ex_k : '0;
    end

    always_ff @(posedge clk_311) begin
        if (reset) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            retry_q <= '0;
            j_q     <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            retry_q <= retry_d;
            j_q     <= j_d;
            k_q     <= k_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign j_out = j_q;
    assign k_out = k_q;
    assign busy  = (state_q == DRIVE) || (state_q == CHECK);
    assign done  = done_q;
    assign err   = err_q;
endmodule

// File: tb/tb_jk_seq_driver_311.sv
// tb_jk_seq_driver_311: scoreboard bench for jk_seq_driver_311 with a JK bank model
module tb_jk_seq_driver_311;
    localparam int MR = 3;

    typedef struct {
        logic [3:0] j;
        logic [3:0] k;
        logic [3:0] q;
        bit         ok;
    } exp_t;

    logic       clk_311 = 1'b0;
    logic       reset, start;
    logic [3:0] target, bank, j_out, k_out;
    logic       busy, done, err;
    logic [3:0] stuck = 4'b0000;
    logic [3:0] preset_v = 4'b0000;
    logic       preset_en = 1'b1;
    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;

    jk_seq_driver_311 #(.WIDTH(4), .MAX_RETRY(MR)) dut (
        .clk_311(clk_311), .reset(reset), .start(start), .target(target), .q_in(bank),
        .j_out(j_out), .k_out(k_out), .busy(busy), .done(done), .err(err)
    );

    always #5 clk_311 = ~clk_311;

    // external bank: JK flip-flops clocked on the falling edge, with optional stuck-at-0 bits
    always @(negedge clk_311) begin
        if (preset_en) bank = preset_v & ~stuck;
        else bank = ((j_out & ~k_out) | (~j_out & ~k_out & bank) | (j_out & k_out & ~bank)) & ~stuck;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exc(input logic [3:0] q, input logic [3:0] t);
`ifdef JK_SEQ_DRIVER_TOGGLE_EN
        return {q ^ t, q ^ t};
`else
        return {~q & t, q & ~t};
`endif
    endfunction

    task automatic set_bank(input logic [3:0] v);
        preset_v = v;
        preset_en = 1'b1;
        @(negedge clk_311);
        #1 preset_en = 1'b0;
    endtask

    task automatic launch(input logic [3:0] t);
        exp_t e;
        {e.j, e.k} = exc(bank, t);
        e.q  = t & ~stuck;
        e.ok = ((t & ~stuck) == t);
        sb.push_back(e);
        start = 1'b1;
        target = t;
        @(posedge clk_311);
        #1 start = 1'b0;
    endtask

    task automatic finish_txn(input bit glitch);
        exp_t e;
        int n;
        e = sb.pop_front();
        chk("j_drive", j_out, e.j);
        chk("k_drive", k_out, e.k);
        chk("busy_drive", busy, 1);
        chk("err_accept", err, 0);
        for (n = 1; n <= 40; n++) begin
            if (glitch && n == 1) begin
                start = 1'b1;
                target = ~target;
            end
            @(posedge clk_311);
            #1 start = 1'b0;
            if (done || err) break;
        end
        chk("latency", n, e.ok ? 2 : 2 * (MR + 1));
        chk("done", done, e.ok);
        chk("err", err, !e.ok);
        chk("busy_end", busy, 0);
        chk("bank", bank, e.q);
        @(posedge clk_311);
        #1;
        chk("done_pulse", done, 0);
        chk("err_sticky", err, !e.ok);
        chk("jk_idle", {j_out, k_out}, 0);
    endtask

    initial begin
        exp_t e;
        bit seen;
        reset = 1'b1; start = 1'b0; target = 4'h0;
        repeat (3) @(posedge clk_311);
        #1;
        chk("rst_jk", {j_out, k_out}, 0);
        chk("rst_flags", {busy, done, err}, 0);
        reset = 1'b0;
        set_bank(4'b0000);
        launch(4'b1010);
        finish_txn(0);
        set_bank(4'b1111);
        launch(4'b0101);
        finish_txn(0);
        set_bank(4'b0000);
        launch(4'b0011);
        finish_txn(1);
        stuck = 4'b0001;
        set_bank(4'b0000);
        launch(4'b0001);
        finish_txn(0);
        launch(bank);
        finish_txn(0);
        stuck = 4'b0000;
        set_bank(4'b0000);
        launch(4'b0110);
        e = sb.pop_front();
        chk("j_drive_r", j_out, e.j);
        chk("k_drive_r", k_out, e.k);
        @(posedge clk_311);
        #1;
        chk("busy_check", busy, 1);
        reset = 1'b1;
        @(posedge clk_311);
        #1 reset = 1'b0;
        chk("rst_mid_jk", {j_out, k_out}, 0);
        chk("rst_mid_flags", {busy, done, err}, 0);
        seen = 0;
        repeat (3) begin
            @(posedge clk_311);
            #1 seen |= done | busy;
        end
        chk("no_done_after_rst", seen, 0);
        reset = 1'b1; start = 1'b1; target = 4'hF;
        @(posedge clk_311);
        #1;
        chk("rst_prio", {busy, j_out, k_out}, 0);
        reset = 1'b0; start = 1'b0;
        repeat (4) begin
            set_bank(4'($urandom));
            launch(4'($urandom));
            finish_txn(0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
